pipe_latch_n: RTL

- Parametrised successor to the fixed per-stage pipeline latches (IF/ID, ID/EX, EX/MM, MM/WB).
- Holds an opaque payload (packed control + data fields) across DEPTH register stages.
- Adds valid tracking, stall/flush control, sticky halt propagation and a bubble counter.
- Instantiated between pipeline stages of the MIPS core; a single instance may cover several back-to-back stages.

---
 rtl/pipe_latch_n.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/pipe_latch_n.sv
// Multi-stage pipeline latch: carries an opaque payload across DEPTH stages with
// valid tracking, stall/flush control, a sticky halt flag and a bubble counter.

module pipe_latch_stage #(
  parameter int DATA_W = 128
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              load,
  input  logic              clr,
  input  logic              in_v,
  input  logic              in_h,
  input  logic [DATA_W-1:0] in_d,
  output logic              v,
  output logic              h,
  output logic [DATA_W-1:0] d
);
  logic              nxt_v, nxt_h;
  logic [DATA_W-1:0] nxt_d;

  // Clear beats load; otherwise hold.
  always_comb begin
    nxt_v = v;
    nxt_h = h;
    nxt_d = d;
    if (clr) begin
      nxt_v = 1'b0;
      nxt_h = 1'b0;
      nxt_d = '0;
    end else if (load) begin
      nxt_v = in_v;
      nxt_h = in_h;
      nxt_d = in_d;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      v <= 1'b0;
      h <= 1'b0;
      d <= '0;
    end else begin
      v <= nxt_v;
      h <= nxt_h;
      d <= nxt_d;
    end
  end
endmodule

module pipe_latch_n #(
  parameter int               DATA_W     = 128,
  parameter int               DEPTH      = 1,
  parameter logic [DEPTH-1:0] FLUSH_MASK = {DEPTH{1'b1}},
  parameter int               CNT_W      = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              en,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              in_halt,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic              out_halt,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  bubble_cnt
);
  generate
    if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
      $error("pipe_latch_n: DEPTH must be 1..4");
    end
  endgenerate

  // Index 0 is the conditioned input entry; index i+1 is stage i.
  logic [DEPTH:0]             vld_pipe, hlt_pipe;
  logic [DEPTH:0][DATA_W-1:0] dat_pipe;
  logic [DEPTH-1:0]           fd_v, fd_h;
  logic [DEPTH-1:0][DATA_W-1:0] fd_d;
  logic                       adv;
  logic                       halt_q;
  logic [CNT_W-1:0]           cnt_q;

  assign adv         = en & ~stall;
  assign vld_pipe[0] = in_valid;
  assign hlt_pipe[0] = in_halt & in_valid;
  assign dat_pipe[0] = in_valid ? in_data : '0;

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_stage
      // A stage fed by a neighbour that is being flushed sees that neighbour's zeroed value.
      if (i == 0) begin : g_feed_in
        assign fd_v[i] = vld_pipe[0];
        assign fd_h[i] = hlt_pipe[0];
        assign fd_d[i] = dat_pipe[0];
      end else begin : g_feed_up
        logic keep;
        assign keep    = ~(flush & FLUSH_MASK[i-1]);
        assign fd_v[i] = vld_pipe[i] & keep;
        assign fd_h[i] = hlt_pipe[i] & keep;
        assign fd_d[i] = keep ? dat_pipe[i] : '0;
      end

      pipe_latch_stage #(.DATA_W(DATA_W)) u_stage (
        .CLK  (CLK),
        .nRST (nRST),
        .load (adv),
        .clr  (flush & FLUSH_MASK[i]),
        .in_v (fd_v[i]),
        .in_h (fd_h[i]),
        .in_d (fd_d[i]),
        .v    (vld_pipe[i+1]),
        .h    (hlt_pipe[i+1]),
        .d    (dat_pipe[i+1])
      );
    end
  endgenerate

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      halt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (adv && !(flush && FLUSH_MASK[DEPTH-1]) && fd_v[DEPTH-1] && fd_h[DEPTH-1])
        halt_q <= 1'b1;
      if (adv && !vld_pipe[DEPTH] && cnt_q != {CNT_W{1'b1}})
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign out_valid  = vld_pipe[DEPTH];
  assign out_data   = dat_pipe[DEPTH];
  assign out_halt   = halt_q;
  assign bubble_cnt = cnt_q;

  always_ff @(posedge CLK) begin
    if (nRST) assert (!$isunknown({en, stall, flush}))
      else $error("pipe_latch_n: X on en/stall/flush");
  end
endmodule
